audio_pdm_receiver: RTL and testbench

AUDIO_PDM_RECEIVER -- requirements
Module: audio_pdm_receiver

---
 rtl/audio_pkg.sv | 19 +
 rtl/pdm_clk_divider.sv | 37 +++
 rtl/audio_pdm_receiver.sv | 96 +++++++++
 tb/tb_audio_pdm_receiver.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the ones-count to sample mapping.
// Used by the PDM receiver and the PWM generator.
package audio_pkg;

    localparam int AUDIO_W    = 12;
    localparam int PDM_WINDOW = 4096;
    localparam int WIN_W      = $clog2(PDM_WINDOW);
    localparam int ONES_W     = WIN_W + 1;

    // A full window of ones (4096) maps to 4095; an empty window stays at 0.
    function automatic logic [AUDIO_W-1:0] ones_to_sample(
        input logic [ONES_W-1:0] n
    );
        logic [ONES_W-1:0] m;
        m = (n == '0) ? '0 : n - ONES_W'(1);
        return m[AUDIO_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_clk_divider.sv
// Bit clock generator for the PDM source.
// Produces pdm_clk and a one-cycle strobe at the end of each bit period.
module pdm_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic pdm_clk,
    output logic bit_stb
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);

    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_div_nxt;
    logic             r_pdm_clk;

    assign w_div_nxt = (r_div_cnt == LAST) ? '0 : r_div_cnt + CNT_W'(1);

    // Advance the divider; pdm_clk follows the count it is moving to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_pdm_clk <= 1'b0;
        end else if (ena) begin
            r_div_cnt <= w_div_nxt;
            r_pdm_clk <= (w_div_nxt < HALF);
        end
    end

    assign pdm_clk = r_pdm_clk;
    assign bit_stb = ena && (r_div_cnt == LAST);

endmodule

// File: rtl/audio_pdm_receiver.sv
// PDM to 12-bit PCM decimator using a 4096-bit boxcar window.
// Results are offered on a valid/ready port; unconsumed ones get dropped.
module audio_pdm_receiver
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               pdm_in,
    output logic               pdm_clk,
    output logic [AUDIO_W-1:0] audio,
    output logic               audio_valid,
    input  logic               audio_ready,
    output logic               overrun
);

    logic               r_sync1;
    logic               r_sync2;
    logic [ONES_W-1:0]  r_ones;
    logic [WIN_W-1:0]   r_bits;
    logic [AUDIO_W-1:0] r_audio;
    logic               r_valid;
    logic               r_overrun;

    logic               w_bit_stb;
    logic               w_close;
    logic               w_accept;
    logic [ONES_W-1:0]  w_ones_tot;
    logic [AUDIO_W-1:0] w_result;

    pdm_clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .pdm_clk (pdm_clk),
        .bit_stb (w_bit_stb)
    );

    assign w_ones_tot = r_ones + ONES_W'(r_sync2);
    assign w_close    = w_bit_stb && (r_bits == WIN_W'(PDM_WINDOW - 1));
    assign w_result   = ones_to_sample(w_ones_tot);
    assign w_accept   = !r_valid || audio_ready;

    // Bring the asynchronous PDM line into the clk domain every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pdm_in;
            r_sync2 <= r_sync1;
        end
    end

    // Count ones over the window; restart with no gap at the closing bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones <= '0;
            r_bits <= '0;
        end else if (w_bit_stb) begin
            if (w_close) begin
                r_ones <= '0;
                r_bits <= '0;
            end else begin
                r_ones <= w_ones_tot;
                r_bits <= r_bits + WIN_W'(1);
            end
        end
    end

    // Output slot: load on close if free or draining, else drop and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_audio   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_close && !w_accept;
            if (w_close && w_accept) begin
                r_audio <= w_result;
                r_valid <= 1'b1;
            end else if (r_valid && audio_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign audio       = r_audio;
    assign audio_valid = r_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_audio_pdm_receiver.sv
// Scenario bench for audio_pdm_receiver against a window-level model.
// Each pdm bit is driven by its position inside the decimation window.
module tb_audio_pdm_receiver;
    import audio_pkg::*;

    localparam int DIV  = 2;
    localparam int WIN  = PDM_WINDOW;
    localparam int WCYC = WIN * DIV;

    localparam int M_ZERO   = 0;
    localparam int M_ONE    = 1;
    localparam int M_ALT    = 2;
    localparam int M_SINGLE = 3;
    localparam int M_ALLBUT = 4;
    localparam int M_RAND   = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ena = 1'b0;
    logic               pdm_in = 1'b0;
    logic               audio_ready = 1'b1;
    logic               pdm_clk;
    logic [AUDIO_W-1:0] audio;
    logic               audio_valid;
    logic               overrun;

    int errors = 0;
    int checks = 0;

    int                 e = 0;
    int                 ones = 0;
    int                 bits = 0;
    bit                 h0 = 1'b0;
    bit                 h1 = 1'b0;
    logic [AUDIO_W-1:0] m_audio = '0;
    bit                 m_valid = 1'b0;
    bit                 m_over = 1'b0;
    bit                 m_pclk = 1'b0;

    int wbase = 0;
    int wmode [16];
    bit rnd [WIN];

    always #5 clk = ~clk;

    audio_pdm_receiver #(
        .CLK_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .pdm_in      (pdm_in),
        .pdm_clk     (pdm_clk),
        .audio       (audio),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .overrun     (overrun)
    );

    function automatic bit pat(input int md, input int pos);
        case (md)
            M_ONE:    return 1'b1;
            M_ALT:    return (pos % 2) == 0;
            M_SINGLE: return pos == 100;
            M_ALLBUT: return pos != 7;
            M_RAND:   return rnd[pos];
            default:  return 1'b0;
        endcase
    endfunction

    // Drive the bit destined for the upcoming strobe, clock once, update model.
    task automatic step();
        int k;
        int wi;
        int res;
        bit closed;
        k  = (e + (ena ? 2 : 0)) / DIV;
        wi = wbase + k / WIN;
        if (wi > 15) wi = 15;
        pdm_in = pat(wmode[wi], k % WIN);
        @(posedge clk);
        closed = 1'b0;
        res    = 0;
        if (rst) begin
            e = 0; ones = 0; bits = 0; h0 = 0; h1 = 0;
            m_audio = '0; m_valid = 0; m_over = 0; m_pclk = 0;
        end else begin
            if (ena && (e % DIV) == DIV - 1) begin
                ones += int'(h1);
                bits++;
                if (bits == WIN) begin
                    closed = 1'b1;
                    res    = (ones == 0) ? 0 : ones - 1;
                    ones   = 0;
                    bits   = 0;
                end
            end
            if (ena) begin
                e++;
                m_pclk = (e % DIV) < (DIV / 2);
            end
            m_over = 1'b0;
            if (closed) begin
                if (!m_valid || audio_ready) begin
                    m_audio = AUDIO_W'(res);
                    m_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && audio_ready) begin
                m_valid = 1'b0;
            end
            h1 = h0;
            h0 = pdm_in;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; audio_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({pdm_clk, audio_valid, overrun, audio} !== '0) begin
            errors++;
            $display("FAIL reset_state: got clk=%0b v=%0b ov=%0b a=%0d, want all 0",
                     pdm_clk, audio_valid, overrun, audio);
        end
        rst = 1'b0; ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({pdm_clk, audio_valid, overrun, audio} !==
                {m_pclk, m_valid, m_over, m_audio}) begin
                errors++;
                $display("FAIL reset_idle: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                         pdm_clk, audio_valid, overrun, audio,
                         m_pclk, m_valid, m_over, m_audio);
            end
        end
    endtask

    task automatic test_const_one();
        int n;
        ena = 1'b1; audio_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (n < WCYC + 20) begin
                step(); n++;
                checks++;
                if ({pdm_clk, audio_valid, overrun, audio} !==
                    {m_pclk, m_valid, m_over, m_audio}) begin
                    errors++;
                    $display("FAIL const_one_cyc %0d: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                             n, pdm_clk, audio_valid, overrun, audio,
                             m_pclk, m_valid, m_over, m_audio);
                end
                if (audio_valid === 1'b1) break;
            end
            checks++;
            if (n !== WCYC) begin
                errors++;
                $display("FAIL const_one_period: got %0d cycles, want %0d", n, WCYC);
            end
            checks++;
            if (audio !== 12'd4095) begin
                errors++;
                $display("FAIL const_one_value: got %0d, want 4095", audio);
            end
        end
    endtask

    task automatic test_single_one();
        int n;
        n = 0;
        while (n < WCYC + 20) begin
            step(); n++;
            checks++;
            if ({pdm_clk, audio_valid, overrun, audio} !==
                {m_pclk, m_valid, m_over, m_audio}) begin
                errors++;
                $display("FAIL single_cyc %0d: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                         n, pdm_clk, audio_valid, overrun, audio,
                         m_pclk, m_valid, m_over, m_audio);
            end
            if (audio_valid === 1'b1) break;
        end
        checks++;
        if (n !== WCYC || audio !== 12'd0) begin
            errors++;
            $display("FAIL single_one: got %0d after %0d cycles, want 0 after %0d",
                     audio, n, WCYC);
        end
    endtask

    task automatic test_overrun();
        int n;
        int ov_cnt;
        int ov_at;
        step();
        audio_ready = 1'b0;
        n = 0;
        while (n < WCYC + 20) begin
            step(); n++;
            if (audio_valid === 1'b1) break;
        end
        checks++;
        if (audio_valid !== 1'b1 || audio !== 12'd2047) begin
            errors++;
            $display("FAIL alt_value: got v=%0b a=%0d, want v=1 a=2047", audio_valid, audio);
        end
        ov_cnt = 0;
        ov_at  = -1;
        for (int i = 1; i <= WCYC + 4; i++) begin
            step();
            checks++;
            if ({pdm_clk, audio_valid, overrun, audio} !==
                {m_pclk, m_valid, m_over, m_audio}) begin
                errors++;
                $display("FAIL overrun_cyc %0d: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                         i, pdm_clk, audio_valid, overrun, audio,
                         m_pclk, m_valid, m_over, m_audio);
            end
            if (overrun === 1'b1) begin
                ov_cnt++;
                ov_at = i;
            end
        end
        checks++;
        if (ov_cnt !== 1 || ov_at !== WCYC) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d pulses at %0d, want 1 at %0d",
                     ov_cnt, ov_at, WCYC);
        end
        checks++;
        if (audio_valid !== 1'b1 || audio !== 12'd2047) begin
            errors++;
            $display("FAIL overrun_hold: got v=%0b a=%0d, want v=1 a=2047", audio_valid, audio);
        end
        audio_ready = 1'b1;
        step();
        checks++;
        if (audio_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_drain: got valid=%0b, want 0", audio_valid);
        end
    endtask

    task automatic test_const_zero();
        int n;
        int ov_cnt;
        n = 0;
        ov_cnt = 0;
        while (n < WCYC + 20) begin
            step(); n++;
            checks++;
            if ({pdm_clk, audio_valid, overrun, audio} !==
                {m_pclk, m_valid, m_over, m_audio}) begin
                errors++;
                $display("FAIL zero_cyc %0d: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                         n, pdm_clk, audio_valid, overrun, audio,
                         m_pclk, m_valid, m_over, m_audio);
            end
            if (overrun === 1'b1) ov_cnt++;
            if (audio_valid === 1'b1) break;
        end
        checks++;
        if (audio_valid !== 1'b1 || audio !== 12'd0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL const_zero: got v=%0b a=%0d ov=%0d, want v=1 a=0 ov=0",
                     audio_valid, audio, ov_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 1000 * DIV; i++) begin
            audio_ready = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({pdm_clk, audio_valid, overrun, audio} !==
                {m_pclk, m_valid, m_over, m_audio}) begin
                errors++;
                $display("FAIL premid_cyc %0d: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                         i, pdm_clk, audio_valid, overrun, audio,
                         m_pclk, m_valid, m_over, m_audio);
            end
        end
        wbase = 7;
        rst = 1'b1; audio_ready = 1'b1;
        step();
        checks++;
        if ({pdm_clk, audio_valid, overrun, audio} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got clk=%0b v=%0b ov=%0b a=%0d, want all 0",
                     pdm_clk, audio_valid, overrun, audio);
        end
        rst = 1'b0;
    endtask

    task automatic test_ena_gate();
        int n;
        int pc;
        int want;
        logic held;
        pc = 0;
        for (int i = 0; i < WIN; i++) pc += int'(rnd[i]);
        want = (pc == 0) ? 0 : pc - 1;
        ena = 1'b0;
        n = 0;
        repeat (2) begin
            step(); n++;
        end
        ena = 1'b1;
        while (n < WCYC + 102 + 20) begin
            if (n == 500 * DIV + 2) begin
                ena  = 1'b0;
                held = pdm_clk;
                for (int g = 0; g < 100; g++) begin
                    audio_ready = 1'($urandom_range(0, 1));
                    step(); n++;
                    checks++;
                    if (pdm_clk !== held || audio_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gate_freeze %0d: got clk=%0b v=%0b, want clk=%0b v=0",
                                 g, pdm_clk, audio_valid, held);
                    end
                end
                ena = 1'b1;
            end
            audio_ready = 1'($urandom_range(0, 1));
            step(); n++;
            checks++;
            if ({pdm_clk, audio_valid, overrun, audio} !==
                {m_pclk, m_valid, m_over, m_audio}) begin
                errors++;
                $display("FAIL gate_cyc %0d: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                         n, pdm_clk, audio_valid, overrun, audio,
                         m_pclk, m_valid, m_over, m_audio);
            end
            if (audio_valid === 1'b1) break;
        end
        checks++;
        if (n !== WCYC + 102) begin
            errors++;
            $display("FAIL gate_timing: got %0d cycles, want %0d", n, WCYC + 102);
        end
        checks++;
        if (audio !== AUDIO_W'(want)) begin
            errors++;
            $display("FAIL gate_value: got %0d, want %0d", audio, want);
        end
    endtask

    initial begin
        for (int i = 0; i < WIN; i++) rnd[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) wmode[i] = M_RAND;
        wmode[0] = M_ONE;
        wmode[1] = M_ONE;
        wmode[2] = M_SINGLE;
        wmode[3] = M_ALT;
        wmode[4] = M_ALLBUT;
        wmode[5] = M_ZERO;
        wmode[6] = M_ONE;
        wmode[7] = M_RAND;
        test_reset();
        test_const_one();
        test_single_one();
        test_overrun();
        test_const_zero();
        test_reset_mid();
        test_ena_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
